// File: rtl/axi_lite_txn_monitor.sv
// Passive AXI-Lite transaction monitor: per-channel read/write counters, an event log FIFO,
// a per-handshake watchdog and VALID-drop detection across NUM_CH interconnect slave ports.
module axi_lite_txn_monitor #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int LOG_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 50000,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int EVT_W = CH_W + 1 + ADDR_W + DATA_W
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       mon_awvalid,
  input  logic [NUM_CH-1:0]       mon_awready,
  input  logic [NUM_CH*ADDR_W-1:0] mon_awaddr,
  input  logic [NUM_CH-1:0]       mon_wvalid,
  input  logic [NUM_CH-1:0]       mon_wready,
  input  logic [NUM_CH*DATA_W-1:0] mon_wdata,
  input  logic [NUM_CH-1:0]       mon_arvalid,
  input  logic [NUM_CH-1:0]       mon_arready,
  input  logic [NUM_CH*ADDR_W-1:0] mon_araddr,
  input  logic [NUM_CH-1:0]       mon_rvalid,
  input  logic [NUM_CH-1:0]       mon_rready,
  input  logic [NUM_CH*DATA_W-1:0] mon_rdata,
  output logic [NUM_CH*CNT_W-1:0] wr_count,
  output logic [NUM_CH*CNT_W-1:0] rd_count,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [EVT_W-1:0]        evt_data,
  output logic                    evt_overflow,
  output logic                    stall_err,
  output logic [CH_W-1:0]         stall_ch,
  output logic                    proto_err
);
  localparam int NS     = 2 * NUM_CH;
  localparam int SLOT_W = $clog2(NS);
  localparam int DEPTH  = 2 ** LOG_DEPTH;
  localparam int WD_W   = $clog2(TIMEOUT_CYC + 1);

  typedef struct packed {
    logic                 aw_got;
    logic                 w_got;
    logic                 rd_out;
    logic [ADDR_W-1:0]    awaddr;
    logic [DATA_W-1:0]    wdata;
    logic [ADDR_W-1:0]    araddr;
    logic [CNT_W-1:0]     wr_cnt;
    logic [CNT_W-1:0]     rd_cnt;
    logic [3:0][WD_W-1:0] wd_cnt;  // index 0..3 = AW, W, AR, R
  } ch_t;

  typedef struct packed {
    logic             vld;
    logic [EVT_W-1:0] evt;
  } slot_t;

  ch_t                ch_q [NUM_CH];
  ch_t                ch_d [NUM_CH];
  slot_t              slot_q [NS];
  slot_t              slot_d [NS];
  logic [SLOT_W-1:0]  rr_q, rr_d;
  logic [LOG_DEPTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EVT_W-1:0]   mem_q [DEPTH];
  logic               evt_overflow_q, evt_overflow_d;
  logic               stall_err_q, stall_err_d;
  logic               proto_err_q, proto_err_d;
  logic [CH_W-1:0]    stall_ch_q, stall_ch_d;

  logic               fifo_empty, fifo_full, push, pop;
  logic [SLOT_W-1:0]  gnt;
  logic [EVT_W-1:0]   push_data;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {LOG_DEPTH{1'b0}}});
  assign pop        = evt_ready & ~fifo_empty;

  // Round-robin search starting at rr_q; a same-cycle pop frees room in a full FIFO.
  always_comb begin
    logic found;
    found     = 1'b0;
    gnt       = '0;
    for (int k = 0; k < NS; k++) begin
      int j;
      j = int'(rr_q) + k;
      if (j >= NS) j = j - NS;
      if (!found && slot_q[SLOT_W'(j)].vld) begin
        found = 1'b1;
        gnt   = SLOT_W'(j);
      end
    end
    push      = found & (~fifo_full | pop);
    push_data = slot_q[gnt].evt;
  end

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    logic [3:0]      vld, rdy;
    logic            stall_hit;
    logic [CH_W-1:0] hit_ch;
    ch_d           = ch_q;
    slot_d         = slot_q;
    rr_d           = rr_q;
    wr_ptr_d       = wr_ptr_q + (LOG_DEPTH+1)'(push);
    rd_ptr_d       = rd_ptr_q + (LOG_DEPTH+1)'(pop);
    evt_overflow_d = evt_overflow_q;
    stall_err_d    = stall_err_q;
    stall_ch_d     = stall_ch_q;
    proto_err_d    = proto_err_q;
    vld            = '0;
    rdy            = '0;
    stall_hit      = 1'b0;
    hit_ch         = '0;

    // Drain first so a completion may reuse a slot emptied this cycle.
    if (push) begin
      slot_d[gnt].vld = 1'b0;
      rr_d = (gnt == SLOT_W'(NS - 1)) ? '0 : gnt + SLOT_W'(1);
    end

    for (int i = 0; i < NUM_CH; i++) begin
      vld = {mon_rvalid[i], mon_arvalid[i], mon_wvalid[i], mon_awvalid[i]};
      rdy = {mon_rready[i], mon_arready[i], mon_wready[i], mon_awready[i]};

      for (int k = 0; k < 4; k++) begin
        if (vld[k] && !rdy[k]) begin
          if (ch_q[i].wd_cnt[k] >= WD_W'(TIMEOUT_CYC - 1) && !stall_hit) begin
            stall_hit = 1'b1;
            hit_ch    = CH_W'(i);
          end
          if (ch_q[i].wd_cnt[k] != WD_W'(TIMEOUT_CYC))
            ch_d[i].wd_cnt[k] = ch_q[i].wd_cnt[k] + WD_W'(1);
        end else begin
          // A nonzero count means VALID was waiting at the previous edge.
          if (!vld[k] && ch_q[i].wd_cnt[k] != '0) proto_err_d = 1'b1;
          ch_d[i].wd_cnt[k] = '0;
        end
      end

      if (vld[0] && rdy[0]) begin
        if (ch_q[i].aw_got) proto_err_d = 1'b1;
        ch_d[i].aw_got = 1'b1;
        ch_d[i].awaddr = mon_awaddr[i*ADDR_W +: ADDR_W];
      end
      if (vld[1] && rdy[1]) begin
        if (ch_q[i].w_got) proto_err_d = 1'b1;
        ch_d[i].w_got = 1'b1;
        ch_d[i].wdata = mon_wdata[i*DATA_W +: DATA_W];
      end
      if (ch_d[i].aw_got && ch_d[i].w_got) begin
        ch_d[i].aw_got = 1'b0;
        ch_d[i].w_got  = 1'b0;
        if (ch_q[i].wr_cnt != '1) ch_d[i].wr_cnt = ch_q[i].wr_cnt + CNT_W'(1);
        if (slot_d[2*i].vld) evt_overflow_d = 1'b1;
        else slot_d[2*i] = {1'b1, CH_W'(i), 1'b1, ch_d[i].awaddr, ch_d[i].wdata};
      end

      if (vld[3] && rdy[3]) begin
        if (!ch_q[i].rd_out) begin
          proto_err_d = 1'b1;
        end else begin
          ch_d[i].rd_out = 1'b0;
          if (ch_q[i].rd_cnt != '1) ch_d[i].rd_cnt = ch_q[i].rd_cnt + CNT_W'(1);
          if (slot_d[2*i+1].vld) evt_overflow_d = 1'b1;
          else slot_d[2*i+1] = {1'b1, CH_W'(i), 1'b0, ch_q[i].araddr,
                                mon_rdata[i*DATA_W +: DATA_W]};
        end
      end
      if (vld[2] && rdy[2]) begin
        if (ch_q[i].rd_out) proto_err_d = 1'b1;
        ch_d[i].rd_out = 1'b1;
        ch_d[i].araddr = mon_araddr[i*ADDR_W +: ADDR_W];
      end
    end

    if (stall_hit) begin
      stall_err_d = 1'b1;
      if (!stall_err_q) stall_ch_d = hit_ch;
    end

    if (clear) begin
      for (int i = 0; i < NUM_CH; i++) ch_d[i] = '0;
      for (int s = 0; s < NS; s++) slot_d[s] = '0;
      rr_d           = '0;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      evt_overflow_d = 1'b0;
      stall_err_d    = 1'b0;
      stall_ch_d     = '0;
      proto_err_d    = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
      for (int s = 0; s < NS; s++) slot_q[s] <= '0;
      rr_q           <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      evt_overflow_q <= 1'b0;
      stall_err_q    <= 1'b0;
      stall_ch_q     <= '0;
      proto_err_q    <= 1'b0;
    end else begin
      ch_q           <= ch_d;
      slot_q         <= slot_d;
      rr_q           <= rr_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      evt_overflow_q <= evt_overflow_d;
      stall_err_q    <= stall_err_d;
      stall_ch_q     <= stall_ch_d;
      proto_err_q    <= proto_err_d;
    end
  end

  // NOTE: log storage is left unreset; the pointers define validity and evt_data is masked when empty.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q[LOG_DEPTH-1:0]] <= push_data;
  end

  always_comb begin
    wr_count = '0;
    rd_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_count[i*CNT_W +: CNT_W] = ch_q[i].wr_cnt;
      rd_count[i*CNT_W +: CNT_W] = ch_q[i].rd_cnt;
    end
  end

  assign evt_valid    = ~fifo_empty;
  assign evt_data     = fifo_empty ? '0 : mem_q[rd_ptr_q[LOG_DEPTH-1:0]];
  assign evt_overflow = evt_overflow_q;
  assign stall_err    = stall_err_q;
  assign stall_ch     = stall_ch_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_axi_lite_txn_monitor.sv
// Directed bench for axi_lite_txn_monitor: stimulus pushes expected events into a queue,
// a negedge monitor pops and compares each event the DUT hands out.
module tb_axi_lite_txn_monitor;
  localparam int NUM_CH      = 2;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int CNT_W       = 16;
  localparam int LOG_DEPTH   = 4;
  localparam int TIMEOUT_CYC = 100;
  localparam int CH_W        = 1;
  localparam int EVT_W       = CH_W + 1 + ADDR_W + DATA_W;

  logic                     aclk = 1'b0;
  logic                     areset, clear, evt_ready;
  logic [NUM_CH-1:0]        mon_awvalid, mon_awready, mon_wvalid, mon_wready;
  logic [NUM_CH-1:0]        mon_arvalid, mon_arready, mon_rvalid, mon_rready;
  logic [NUM_CH*ADDR_W-1:0] mon_awaddr, mon_araddr;
  logic [NUM_CH*DATA_W-1:0] mon_wdata, mon_rdata;
  logic [NUM_CH*CNT_W-1:0]  wr_count, rd_count;
  logic                     evt_valid, evt_overflow, stall_err, proto_err;
  logic [EVT_W-1:0]         evt_data;
  logic [CH_W-1:0]          stall_ch;

  int vectors     = 0;
  int miscompares = 0;
  logic [EVT_W-1:0] exp_q [$];

  axi_lite_txn_monitor #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
    .LOG_DEPTH(LOG_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .aclk(aclk), .areset(areset), .clear(clear),
    .mon_awvalid(mon_awvalid), .mon_awready(mon_awready), .mon_awaddr(mon_awaddr),
    .mon_wvalid(mon_wvalid), .mon_wready(mon_wready), .mon_wdata(mon_wdata),
    .mon_arvalid(mon_arvalid), .mon_arready(mon_arready), .mon_araddr(mon_araddr),
    .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rdata(mon_rdata),
    .wr_count(wr_count), .rd_count(rd_count),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_overflow(evt_overflow), .stall_err(stall_err), .stall_ch(stall_ch),
    .proto_err(proto_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EVT_W-1:0] ev(input int ch, input logic is_wr,
                                          input logic [31:0] a, input logic [31:0] d);
    return {CH_W'(ch), is_wr, a, d};
  endfunction

  // Scoreboard monitor: a pop happens at the next rising edge when valid & ready.
  always @(negedge aclk) begin
    if (!areset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL evt_unexpected: got 0x%0h, expected no event", evt_data);
      end else begin
        check("evt_data", evt_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic fire_wr(input int ch, input logic [31:0] a, input logic [31:0] d);
    mon_awvalid[ch] = 1'b1; mon_awready[ch] = 1'b1; mon_awaddr[ch*ADDR_W +: ADDR_W] = a;
    mon_wvalid[ch]  = 1'b1; mon_wready[ch]  = 1'b1; mon_wdata[ch*DATA_W +: DATA_W]  = d;
    tick();
    mon_awvalid[ch] = 1'b0; mon_awready[ch] = 1'b0;
    mon_wvalid[ch]  = 1'b0; mon_wready[ch]  = 1'b0;
  endtask

  task automatic fire_aw(input int ch, input logic [31:0] a);
    mon_awvalid[ch] = 1'b1; mon_awready[ch] = 1'b1; mon_awaddr[ch*ADDR_W +: ADDR_W] = a;
    tick();
    mon_awvalid[ch] = 1'b0; mon_awready[ch] = 1'b0;
  endtask

  task automatic fire_w(input int ch, input logic [31:0] d);
    mon_wvalid[ch] = 1'b1; mon_wready[ch] = 1'b1; mon_wdata[ch*DATA_W +: DATA_W] = d;
    tick();
    mon_wvalid[ch] = 1'b0; mon_wready[ch] = 1'b0;
  endtask

  task automatic fire_ar(input int ch, input logic [31:0] a);
    mon_arvalid[ch] = 1'b1; mon_arready[ch] = 1'b1; mon_araddr[ch*ADDR_W +: ADDR_W] = a;
    tick();
    mon_arvalid[ch] = 1'b0; mon_arready[ch] = 1'b0;
  endtask

  task automatic fire_r(input int ch, input logic [31:0] d);
    mon_rvalid[ch] = 1'b1; mon_rready[ch] = 1'b1; mon_rdata[ch*DATA_W +: DATA_W] = d;
    tick();
    mon_rvalid[ch] = 1'b0; mon_rready[ch] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    areset = 1'b1; clear = 1'b0; evt_ready = 1'b1;
    mon_awvalid = '0; mon_awready = '0; mon_awaddr = '0;
    mon_wvalid  = '0; mon_wready  = '0; mon_wdata  = '0;
    mon_arvalid = '0; mon_arready = '0; mon_araddr = '0;
    mon_rvalid  = '0; mon_rready  = '0; mon_rdata  = '0;
    tick(3);
    check("rst_wr_count", wr_count, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_overflow", evt_overflow, 0);
    check("rst_stall_err", stall_err, 0);
    check("rst_proto_err", proto_err, 0);
    areset = 1'b0;
    tick(2);

    // 1: ch0 AW+W in the same cycle, event one edge after the handshake
    exp_q.push_back(ev(0, 1'b1, 32'h1000_0000, 32'h55));
    fire_wr(0, 32'h1000_0000, 32'h55);
    check("t1_evt_valid_edge_n", evt_valid, 0);
    tick();
    check("t1_evt_valid_edge_n1", evt_valid, 1);
    tick(3);
    check("t1_wr_count0", wr_count[0 +: CNT_W], 1);

    // 2: ch1 AW then W four cycles later
    exp_q.push_back(ev(1, 1'b1, 32'h2000_0000, 32'hAA));
    fire_aw(1, 32'h2000_0000);
    tick(3);
    check("t2_no_evt_before_w", evt_valid, 0);
    check("t2_wr_count1_pending", wr_count[CNT_W +: CNT_W], 0);
    fire_w(1, 32'hAA);
    tick(3);
    check("t2_wr_count1", wr_count[CNT_W +: CNT_W], 1);
    check("t2_proto_err", proto_err, 0);
    check("t2_stall_err", stall_err, 0);

    // 3: ch0 AR, R two cycles later
    exp_q.push_back(ev(0, 1'b0, 32'h0000_0004, 32'h0020_a023));
    fire_ar(0, 32'h0000_0004);
    tick();
    fire_r(0, 32'h0020_a023);
    tick(3);
    check("t3_rd_count0", rd_count[0 +: CNT_W], 1);
    check("t3_queue_empty", exp_q.size(), 0);

    // synchronous clear
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_wr_count", wr_count, 0);
    check("clr_rd_count", rd_count, 0);

    // 4: consumer stalled, 20 writes: 16 in FIFO, 1 parked in the slot, 3 dropped
    evt_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k < 17) exp_q.push_back(ev(0, 1'b1, 32'h100 + 32'(4*k), 32'(k + 1)));
      fire_wr(0, 32'h100 + 32'(4*k), 32'(k + 1));
      tick();
      if (k == 16) check("t4_no_overflow_at_17", evt_overflow, 0);
    end
    tick(3);
    check("t4_overflow", evt_overflow, 1);
    check("t4_wr_count0", wr_count[0 +: CNT_W], 20);
    check("t4_evt_valid", evt_valid, 1);
    evt_ready = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) tick();
    check("t4_drained", exp_q.size(), 0);
    tick(2);
    check("t4_fifo_empty", evt_valid, 0);

    // 5: ch1 AR stalled for TIMEOUT_CYC edges
    mon_arvalid[1] = 1'b1; mon_arready[1] = 1'b0;
    mon_araddr[ADDR_W +: ADDR_W] = 32'h3000_0000;
    tick(TIMEOUT_CYC - 1);
    check("t5_stall_before", stall_err, 0);
    tick();
    check("t5_stall_err", stall_err, 1);
    check("t5_stall_ch", stall_ch, 1);
    mon_arready[1] = 1'b1;
    tick();
    mon_arvalid[1] = 1'b0; mon_arready[1] = 1'b0;
    exp_q.push_back(ev(1, 1'b0, 32'h3000_0000, 32'hDEAD_BEEF));
    fire_r(1, 32'hDEAD_BEEF);
    tick(3);
    check("t5_rd_count1", rd_count[CNT_W +: CNT_W], 1);
    check("t5_proto_err", proto_err, 0);
    check("t5_stall_sticky", stall_err, 1);

    // 6: AW VALID dropped before READY, then async reset mid-transaction
    mon_awvalid[0] = 1'b1; mon_awready[0] = 1'b0;
    tick();
    mon_awvalid[0] = 1'b0;
    tick();
    check("t6_proto_err", proto_err, 1);
    evt_ready = 1'b0;
    exp_q.push_back(ev(1, 1'b1, 32'h4000_0000, 32'h77));
    fire_wr(1, 32'h4000_0000, 32'h77);
    tick(2);
    check("t6_evt_valid_pre_rst", evt_valid, 1);
    fire_aw(0, 32'h5000_0000);
    #3;
    areset = 1'b1;
    #1;
    exp_q.delete();
    check("t6_rst_wr_count", wr_count, 0);
    check("t6_rst_rd_count", rd_count, 0);
    check("t6_rst_evt_valid", evt_valid, 0);
    check("t6_rst_evt_data", evt_data, 0);
    check("t6_rst_overflow", evt_overflow, 0);
    check("t6_rst_stall_err", stall_err, 0);
    check("t6_rst_stall_ch", stall_ch, 0);
    check("t6_rst_proto_err", proto_err, 0);
    tick(2);
    areset = 1'b0;
    evt_ready = 1'b1;
    tick();
    fire_w(0, 32'h99);
    tick(3);
    check("t6_no_stale_aw", wr_count[0 +: CNT_W], 0);
    check("t6_no_stale_evt", evt_valid, 0);
    check("t6_proto_clean", proto_err, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
